// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'b00,
    PCSRC_REL  = 2'b01,
    PCSRC_RSVD = 2'b10,
    PCSRC_ABS  = 2'b11
  } pcsrc_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch/decode boundary: redirect request from execute plus the instruction handshake.
interface fetch_if #(
  parameter int unsigned W = 32
);
  logic [1:0]   PCsrc;
  logic [W-1:0] BrPC;
  logic [W-1:0] IMM;
  logic [W-1:0] DOutAlu;
  logic         InstrReady;
  logic         InstrValid;
  logic [W-1:0] Instr;
  logic [W-1:0] InstrPC;

  modport master (
    input  PCsrc, BrPC, IMM, DOutAlu, InstrReady,
    output InstrValid, Instr, InstrPC
  );

  modport slave (
    output PCsrc, BrPC, IMM, DOutAlu, InstrReady,
    input  InstrValid, Instr, InstrPC
  );
endinterface

// File: rtl/fetch_buffer.sv
// Prefetch FIFO of {pc, instr} pairs with a combinational head and synchronous flush.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 data_in,
  output fetch_entry_t                 data_out,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr_reg;
  logic [PW-1:0]  rd_ptr_reg;
  logic [CW-1:0]  count_reg;

  // Storage has no reset; the count gates what is visible at the head.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign data_out = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
  assign count    = count_reg;

endmodule

// File: rtl/rom.sv
// Combinational instruction ROM; the image is a fixed pattern derived from the address
// so every word is distinct and predictable.
module rom #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] addr,
  output logic [W-1:0] data
);

  assign data = {addr[W/2-1:0], ~addr[W-1:W/2]};

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch stage: PC register, next-PC selection, ROM read and
// a prefetch buffer feeding decode over valid/ready, flushed on redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned W        = 32,
  parameter int unsigned DEPTH    = 2,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  fetch_if.master                      bus,
  output logic [W-1:0]                 FetchPC,
  output logic [$clog2(DEPTH+1)-1:0]   Count
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  pcsrc_t        pcsrc;
  logic          redirect;
  logic [W-1:0]  target_next;
  logic [W-1:0]  fetch_pc_reg;
  logic [W-1:0]  rom_data;
  logic          valid;
  logic          pop;
  logic          push;
  fetch_entry_t  entry_in;
  fetch_entry_t  head;

  assign pcsrc    = pcsrc_t'(bus.PCsrc);
  assign redirect = (pcsrc == PCSRC_REL) || (pcsrc == PCSRC_ABS);

  always_comb begin
    target_next = (pcsrc == PCSRC_REL) ? (bus.BrPC + bus.IMM) : bus.DOutAlu;
    target_next[1:0] = 2'b00;
  end

  // A redirect squashes everything buffered, so nothing may leave in that cycle.
  assign valid = (Count != '0) && !redirect;
  assign pop   = valid && bus.InstrReady;
  assign push  = !redirect && ((Count < CW'(DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
    end else if (redirect) begin
      fetch_pc_reg <= target_next;
    end else if (push) begin
      fetch_pc_reg <= fetch_pc_reg + W'(PC_STEP);
    end
  end

  rom #(.W(W)) u_rom (
    .addr (fetch_pc_reg),
    .data (rom_data)
  );

  assign entry_in.pc    = XLEN'(fetch_pc_reg);
  assign entry_in.instr = XLEN'(rom_data);

  fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (redirect),
    .data_in  (entry_in),
    .data_out (head),
    .count    (Count)
  );

  assign bus.InstrValid = valid;
  assign bus.Instr      = W'(head.instr);
  assign bus.InstrPC    = W'(head.pc);
  assign FetchPC        = fetch_pc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random traffic, all
// compared against a queue-based model of the fetch rules.
module tb_fetch_unit;

  localparam int unsigned W        = 32;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic [1:0]  count;

  ent_t        q[$];
  logic [31:0] m_pc;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fetch_if #(.W(W)) bus ();

  fetch_unit #(.W(W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .FetchPC (fetch_pc),
    .Count   (count)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input logic r, input logic [1:0] ps, input logic [31:0] br,
                      input logic [31:0] imm, input logic [31:0] alu, input logic rdy);
    logic redir, vld, pop, push;
    rst            = r;
    bus.PCsrc      = ps;
    bus.BrPC       = br;
    bus.IMM        = imm;
    bus.DOutAlu    = alu;
    bus.InstrReady = rdy;
    #1;
    redir = (ps == 2'b01) || (ps == 2'b11);
    vld   = (q.size() != 0) && !redir;
    chk("valid", {31'b0, bus.InstrValid}, {31'b0, vld});
    chk("fetch_pc", fetch_pc, m_pc);
    chk("count", 32'(count), 32'(q.size()));
    if (vld) begin
      chk("instr_pc", bus.InstrPC, q[0].pc);
      chk("instr", bus.Instr, q[0].instr);
    end
    if (r) begin
      q.delete();
      m_pc = RESET_PC;
    end else if (redir) begin
      q.delete();
      m_pc = ((ps == 2'b01) ? br + imm : alu) & ~32'd3;
    end else begin
      pop  = vld && rdy;
      push = (q.size() < DEPTH) || pop;
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{pc: m_pc, instr: rom_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    bus.PCsrc = 2'b00; bus.BrPC = '0; bus.IMM = '0; bus.DOutAlu = '0; bus.InstrReady = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    q.delete();
    m_pc = RESET_PC;

    // Reset state
    rst = 1'b0;
    bus.InstrReady = 1'b1;
    #1;
    chk("rst_fetch_pc", fetch_pc, RESET_PC);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", {31'b0, bus.InstrValid}, 32'd0);
    chk("rst_instr", bus.Instr, 32'd0);
    chk("rst_instr_pc", bus.InstrPC, 32'd0);

    // Streaming with ready held high
    for (int i = 0; i < 6; i++) step(1'b0, 2'b00, 0, 0, 0, 1'b1);

    // Back-pressure after reset: buffer saturates, then drains without gaps
    step(1'b1, 2'b00, 0, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 0, 0, 0, 1'b0);
    #1;
    chk("sat_count", 32'(count), 32'd2);
    chk("sat_fetch_pc", fetch_pc, 32'd8);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 0, 0, 0, 1'b1);

    // Relative redirect with a full buffer
    for (int i = 0; i < 2; i++) step(1'b0, 2'b00, 0, 0, 0, 1'b0);
    step(1'b0, 2'b01, 32'h10, 32'hFFFF_FFF8, 0, 1'b1);
    #1;
    chk("rel_fetch_pc", fetch_pc, 32'h8);
    chk("rel_count", 32'(count), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 0, 0, 0, 1'b1);

    // Absolute redirect with a misaligned target
    step(1'b0, 2'b11, 0, 0, 32'h0000_0043, 1'b1);
    #1;
    chk("abs_fetch_pc", fetch_pc, 32'h40);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 0, 0, 0, 1'b1);

    // Reserved select behaves as sequential
    for (int i = 0; i < 3; i++) step(1'b0, 2'b10, 32'h100, 32'h200, 32'h300, 1'b1);

    // Reset wins over a simultaneous redirect
    for (int i = 0; i < 2; i++) step(1'b0, 2'b00, 0, 0, 0, 1'b0);
    step(1'b1, 2'b11, 0, 0, 32'h80, 1'b0);
    rst = 1'b0;
    bus.PCsrc = 2'b00;
    #1;
    chk("rr_fetch_pc", fetch_pc, RESET_PC);
    chk("rr_count", 32'(count), 32'd0);
    chk("rr_valid", {31'b0, bus.InstrValid}, 32'd0);

    // PC wrap at the top of the address space
    step(1'b0, 2'b11, 0, 0, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 2'b00, 0, 0, 0, 1'b1);
    #1;
    chk("wrap_fetch_pc", fetch_pc, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 0, 0, 0, 1'b1);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      logic       r, rdy;
      logic [1:0] ps;
      int unsigned sel;
      r   = ($urandom_range(0, 59) == 0);
      sel = $urandom_range(0, 11);
      ps  = (sel == 0) ? 2'b01 : (sel == 1) ? 2'b11 : (sel == 2) ? 2'b10 : 2'b00;
      rdy = ($urandom_range(0, 3) != 0);
      step(r, ps, $urandom() & 32'hFFFF_FFFC, $urandom(), $urandom(), rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage that generalises the single-cycle PC/ROM datapath into a decoupled front end. It holds the PC register, computes the next PC and reads the instruction ROM. It also buffers fetched {PC, instruction} pairs in a small FIFO, hands them to decode over a valid/ready handshake, and flushes on control-flow redirects. It sits between the instruction ROM and the decode stage of the pipelined core.

## Interface
- W, 32: data and address width.
- DEPTH, 2: prefetch buffer entries; power of two, at least 2.
- RESET_PC, 0: PC value loaded on reset; word-aligned.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- PCsrc  in  2  redirect select:
  - 00: none.
  - 01: PC-relative, target = BrPC + IMM.
  - 11: absolute, target = DOutAlu.
  - 10: reserved, treated as 00.
- BrPC  in  W  PC of the resolving branch, used when PCsrc=01.
- IMM  in  W  branch/jump immediate.
- DOutAlu  in  W  absolute jump target, used when PCsrc=11.
- InstrReady  in  1  decode accepts an instruction this cycle.
- InstrValid  out  1  the InstrPC/Instr pair is valid.
- Instr  out  W  instruction at the FIFO head.
- InstrPC  out  W  PC of the FIFO head.
- FetchPC  out  W  current fetch PC.
- Count  out  $clog2(DEPTH+1)  number of buffered entries.

## Operation
- Fetch: the ROM is read combinationally at FetchPC.
  - Push {FetchPC, ROM data} when Count < DEPTH, or when Count == DEPTH and a pop occurs in the same cycle.
  - On every push, FetchPC <= FetchPC + 4; otherwise FetchPC holds.
- Pop: occurs when InstrValid && InstrReady.
- InstrValid = (Count != 0) && !redirect, where redirect = (PCsrc == 01 || PCsrc == 11).
- Redirect cycle:
  - The FIFO is cleared and FetchPC <= target with bits [1:0] forced to 0.
  - No push and no pop occur; buffered entries are younger than the branch and are squashed.
  - The combinational InstrValid drop means decode never consumes a squashed entry.
- Arithmetic: all PC sums are modulo 2^W; 0xFFFFFFFC + 4 wraps to 0. IMM is used as given, already sign-extended upstream.
- Simultaneous push and pop: Count is unchanged and FIFO order is preserved.
- Full with no pop: no push, and FetchPC holds.
- Empty with InstrReady high: no pop, InstrValid=0, and Instr/InstrPC are don't-care.
- Back-to-back redirects: each one independently flushes and reloads FetchPC; the last one wins.
- Redirect and rst in the same cycle: rst has priority.

## Timing
- Reset values (edge with rst=1):
  - FetchPC = RESET_PC.
  - Count = 0, FIFO pointers = 0.
  - InstrValid = 0; Instr and InstrPC read 0.
- Reset asserted mid-operation discards all buffered entries at that edge.
- Fetch-to-decode latency is 1 cycle: a pair pushed at edge t is visible at the head in cycle t+1 if the FIFO was empty.
- First instruction after rst deasserts: ROM[RESET_PC] is presented with InstrValid=1 in the 2nd cycle.
- Redirect in cycle t:
  - FetchPC = target in cycle t+1.
  - The target instruction is presented in cycle t+2, a 2-cycle bubble.
- Steady state with InstrReady held high: one instruction per cycle, with no bubbles.

## Structure
- Shared package fetch_pkg:
  - pcsrc_t enum: PCSRC_SEQ=2'b00, PCSRC_REL=2'b01, PCSRC_RSVD=2'b10, PCSRC_ABS=2'b11.
  - PC_STEP = 4.
  - fetch_entry_t struct {pc, instr}.
- Sub-module fetch_buffer: synchronous FIFO of fetch_entry_t.
  - Parameters: DEPTH.
  - Ports: push, pop, flush, data in/out, count.
  - Single storage array with read/write pointers.
- The existing combinational rom is instantiated unchanged. Next-PC selection lives in fetch_unit.

## Test plan
- Reset then InstrReady=1 with ROM[0..3]=A,B,C,D:
  - InstrValid rises in cycle 2.
  - Outputs are (0,A), (4,B), (8,C), (12,D) on consecutive cycles.
- InstrReady=0 for 5 cycles after reset with DEPTH=2:
  - Count saturates at 2 and FetchPC holds at 8.
  - Releasing InstrReady yields PCs 0, 4, 8 with no gaps.
- Relative redirect with PCsrc=01, BrPC=0x10, IMM=0xFFFFFFF8 while Count=2:
  - InstrValid=0 in that cycle and Count=0 at the next edge.
  - Next instruction presented is at InstrPC=0x08, 2 cycles later.
- Absolute redirect with PCsrc=11, DOutAlu=0x0000_0043:
  - FetchPC=0x40; next presented InstrPC=0x40.
- PCsrc=10 (reserved): no flush, and the sequence continues unchanged.
- rst asserted mid-stream with Count=2 and a simultaneous PCsrc=11:
  - Next cycle FetchPC=RESET_PC, Count=0, InstrValid=0.
